// File: rtl/hazard_stall_control.sv
// Pipeline stall scheduler: load-use and branch-operand hazard detection,
// refill-port arbitration between icache and dcache, and a saturating stall counter.
module hazard_stall_control #(
  parameter int REG_ADDR = 5,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [REG_ADDR-1:0] if_id_src1,
  input  logic [REG_ADDR-1:0] if_id_src2,
  input  logic                if_id_uses_src2,
  input  logic                if_id_is_branch,
  input  logic                id_ex_memread,
  input  logic                id_ex_regwrite,
  input  logic [REG_ADDR-1:0] id_ex_dst_reg,
  input  logic                ex_mem_memread,
  input  logic [REG_ADDR-1:0] ex_mem_dst_reg,
  input  logic                req_i,
  input  logic                req_d,
  input  logic                mem_done,
  output logic                gnt_i,
  output logic                gnt_d,
  output logic                pc_write,
  output logic                if_id_write,
  output logic                if_id_bubble,
  output logic                id_ex_bubble,
  output logic                back_write,
  output logic [CNT_W-1:0]    stall_cnt
);

  typedef enum logic [1:0] {IDLE, GNT_D, GNT_I} arb_state_t;

  arb_state_t state, state_next;
  logic id_ex_match, ex_mem_match;
  logic hz, dstall, istall;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // On mem_done the other requester is served directly, skipping IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_d)      state_next = GNT_D;
        else if (req_i) state_next = GNT_I;
      end
      GNT_D: if (mem_done) state_next = req_i ? GNT_I : IDLE;
      GNT_I: if (mem_done) state_next = req_d ? GNT_D : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign gnt_d = (state == GNT_D);
  assign gnt_i = (state == GNT_I);

  assign id_ex_match  = (id_ex_dst_reg != '0) &&
                        ((id_ex_dst_reg == if_id_src1) ||
                         (if_id_uses_src2 && (id_ex_dst_reg == if_id_src2)));
  assign ex_mem_match = (ex_mem_dst_reg != '0) &&
                        ((ex_mem_dst_reg == if_id_src1) ||
                         (if_id_uses_src2 && (ex_mem_dst_reg == if_id_src2)));

  assign hz     = (id_ex_memread && id_ex_match) ||
                  (if_id_is_branch && id_ex_regwrite && id_ex_match) ||
                  (if_id_is_branch && ex_mem_memread && ex_mem_match);
  assign dstall = req_d | gnt_d;
  assign istall = req_i | gnt_i;

  // A data refill freezes everything, so it masks both bubbles
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    back_write   = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_bubble = 1'b0;
    if (!reset) begin
      pc_write     = !(dstall | hz | istall);
      back_write   = !dstall;
      if_id_write  = !(dstall | hz);
      id_ex_bubble = hz & !dstall;
      if_id_bubble = istall & !hz & !dstall;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (!pc_write && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule
